cbus_sram_responder: RTL

CBUS_SRAM_RESPONDER -- requirements
Module: cbus_sram_responder

---
 rtl/cbus_sram_responder_pkg.sv | 42 ++++
 rtl/cbus_sram_responder_sram.sv | 46 ++++
 rtl/cbus_sram_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cbus_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_sram_responder_pkg
//  Description : Shared CBUS request/response types and burst-length codes
//                used by the SRAM responder, its storage array and the bench.
//  Contents    : cbus_len_t  - burst length code (beats - 1)
//                cbus_req_t  - initiator request bundle
//                cbus_resp_t - responder response bundle
//  Revision    : 1.0 - initial release
// ============================================================================
package cbus_sram_responder_pkg;

    // Bytes per bus word; one strobe bit per byte.
    localparam int unsigned CBUS_WORD_BYTES = 8;

    // Encoded as (number of beats - 1).
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/cbus_sram_responder_sram.sv
`default_nettype none
// ============================================================================
//  Module      : sram_byte_en
//  Description : WORDS x 64-bit storage with per-byte write enables, one
//                synchronous write port and one asynchronous read port.
//                Contents are never reset.
//  Ports       : clk   - clock, writes on rising edge
//                we    - write enable
//                be    - byte enables, bit k selects byte k
//                waddr - write word index
//                wdata - write data
//                raddr - read word index
//                rdata - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_byte_en
    import cbus_sram_responder_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [7:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [63:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [63:0]      rdata
);

    logic [63:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < CBUS_WORD_BYTES; k++) begin
                if (be[k]) begin
                    r_mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/cbus_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_sram_responder
//  Description : CBUS burst responder backed by a byte-enabled SRAM. Accepts
//                a request in IDLE, waits WAIT_CYCLES, then serves len+1
//                back-to-back beats with incrementing, wrapping word index.
//  Ports       : clk   - clock, all state on rising edge
//                reset - asynchronous active-low reset
//                req   - request bundle (sampled only in IDLE)
//                resp  - response bundle (all-zero outside BURST)
//  Revision    : 1.0 - initial release
// ============================================================================
module cbus_sram_responder
    import cbus_sram_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  req,
    output cbus_resp_t resp
);

    localparam int unsigned C_IDX_W     = $clog2(MEM_WORDS);
    // Value of the wait counter on the final WAIT cycle.
    localparam logic [3:0]  C_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t              r_state;
    logic [C_IDX_W-1:0]  r_base;       // starting word index, already reduced mod MEM_WORDS
    logic                r_is_write;
    logic [3:0]          r_last_beat;  // index of the final beat (len)
    logic [3:0]          r_beat;
    logic [3:0]          r_wait;

    logic                w_in_burst;
    logic [C_IDX_W-1:0]  w_idx;
    logic [63:0]         w_rdata;
    logic                w_unused;

    // Only the index bits of addr matter: higher bits vanish under the
    // modulo, low three bits select a byte within the word.
    assign w_unused = ^{req.size, req.addr[63:C_IDX_W+3], req.addr[2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_is_write  <= 1'b0;
            r_last_beat <= 4'd0;
            r_beat      <= 4'd0;
            r_wait      <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req.valid) begin
                        r_base      <= req.addr[C_IDX_W+2:3];
                        r_is_write  <= req.is_write;
                        r_last_beat <= req.len;
                        r_beat      <= 4'd0;
                        r_wait      <= 4'd0;
                        r_state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_BURST;
                    end
                end
                ST_WAIT: begin
                    if (r_wait == C_WAIT_LAST) begin
                        r_state <= ST_BURST;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                ST_BURST: begin
                    if (r_beat == r_last_beat) begin
                        r_beat  <= 4'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_beat <= r_beat + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_in_burst = (r_state == ST_BURST);
    // Truncation to C_IDX_W bits gives the wrap past the top of memory.
    assign w_idx      = r_base + C_IDX_W'(r_beat);

    // Reset forces r_state to IDLE asynchronously, so resp clears in the
    // same cycle reset is asserted.
    always_comb begin
        resp = '0;
        if (w_in_burst) begin
            resp.ready = 1'b1;
            resp.last  = (r_beat == r_last_beat);
            resp.data  = r_is_write ? 64'd0 : w_rdata;
        end
    end

    sram_byte_en #(
        .WORDS (MEM_WORDS),
        .IDX_W (C_IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_in_burst & r_is_write),
        .be    (req.strobe),
        .waddr (w_idx),
        .wdata (req.data),
        .raddr (w_idx),
        .rdata (w_rdata)
    );

endmodule
`default_nettype wire
